// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding and the NOP word
// that the ID/EX bubble path loads.
package hazard_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'd0;

  localparam int BUB_W  = 3;
  localparam int WAIT_W = 16;

endpackage

// File: rtl/haz_detect.sv
// Combinational load-use comparator: flags when the ID instruction reads the register a load in EX
// will write. Register 0 is hard-wired and never creates a dependency.
module haz_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rs,
  input  logic                  uses_rt,
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  hazard
);

  logic rd_live;
  logic rs_match;
  logic rt_match;

  assign rd_live  = (rd != '0);
  assign rs_match = uses_rs & (rs == rd);
  assign rt_match = uses_rt & (rt == rd);
  assign hazard   = mem_read & rd_live & (rs_match | rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: keep/flush/bubble controls for load-use, ID redirects and memory waits.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush/freeze event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  id_redirect_i,
  input  logic                  mem_busy_i,
  output logic                  pc_keep_o,
  output logic                  if_id_keep_o,
  output logic                  if_flush_o,
  output logic                  id_ex_keep_o,
  output logic                  id_ex_bubble_o,
  output logic                  ex_mem_keep_o,
  output logic                  mem_timeout_o,
  output logic [STATE_W-1:0]    state_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o,
  output logic [31:0]           freeze_cnt_o
`endif
);

  localparam logic [BUB_W-1:0]  BUB_INIT = BUB_W'(LOAD_BUBBLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [BUB_W-1:0]    bub_q, bub_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                timeout_q;
  logic                hazard;
  logic                freeze;
  logic                stall;
  logic                flush;

  haz_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_detect (
    .rs      (id_rs_i),
    .rt      (id_rt_i),
    .uses_rs (id_uses_rs_i),
    .uses_rt (id_uses_rt_i),
    .mem_read(ex_mem_read_i),
    .rd      (ex_rd_i),
    .hazard  (hazard)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      bub_q     <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bub_q     <= bub_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_q | (wait_d >= WAIT_LIM);
    end
  end

  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (mem_busy_i) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else if (hazard && (LOAD_BUBBLES > 1)) begin
          state_d = LOAD_STALL;
          bub_d   = BUB_INIT;
        end
      end
      LOAD_STALL: begin
        // A memory wait pauses the bubble count; the remainder resumes after the freeze.
        if (mem_busy_i) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          bub_d = bub_q - BUB_W'(1);
          if (bub_q <= BUB_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_busy_i) begin
          if (wait_q != '1) begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          wait_d = '0;
          if (bub_q != '0) begin
            state_d = LOAD_STALL;
          end else if (hazard && (LOAD_BUBBLES > 1)) begin
            state_d = LOAD_STALL;
            bub_d   = BUB_INIT;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        bub_d   = '0;
        wait_d  = '0;
      end
    endcase
  end

  // The cycle leaving MEM_WAIT is evaluated like RUN; pending bubbles resume from the next cycle.
  always_comb begin
    freeze = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_busy_i) begin
          freeze = 1'b1;
        end else if (hazard) begin
          stall = 1'b1;
        end else if (id_redirect_i) begin
          flush = 1'b1;
        end
      end
      LOAD_STALL: begin
        if (mem_busy_i) begin
          freeze = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pc_keep_o      = rst_ni & (freeze | stall);
  assign if_id_keep_o   = rst_ni & (freeze | stall);
  assign if_flush_o     = rst_ni & flush;
  assign id_ex_keep_o   = rst_ni & freeze;
  assign id_ex_bubble_o = rst_ni & stall;
  assign ex_mem_keep_o  = rst_ni & freeze;
  assign mem_timeout_o  = rst_ni & timeout_q;
  assign state_o        = rst_ni ? state_q : RUN;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
      if (freeze && (freeze_cnt != '1)) begin
        freeze_cnt <= freeze_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt;
  assign flush_cnt_o  = flush_cnt;
  assign freeze_cnt_o = freeze_cnt;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It produces the keep (stall), flush and bubble controls consumed by the PC register, the IF/ID register and the ID/EX and EX/MEM registers. Three hazard sources drive it: load-use data hazards, taken branches and jumps resolved in ID, and multi-cycle data-memory waits. It sits beside the decode stage and replaces ad-hoc hazard gating.

Parameters:
REG_ADDR_W, 5, register-file index width
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (1..4)
MEM_TIMEOUT, 255, maximum consecutive mem_busy_i cycles before the error flag sets (1..65535)

Ports:
clk_i  in  1  clock; controller state updates on posedge, pipeline registers sample the outputs on negedge
rst_ni  in  1  reset, asynchronous, active-low
id_rs_i  in  REG_ADDR_W  rs index of the instruction in ID
id_rt_i  in  REG_ADDR_W  rt index of the instruction in ID
id_uses_rs_i  in  1  ID instruction reads rs
id_uses_rt_i  in  1  ID instruction reads rt
ex_mem_read_i  in  1  instruction in EX is a load
ex_rd_i  in  REG_ADDR_W  destination index of the EX instruction
id_redirect_i  in  1  taken branch or jump resolved in ID this cycle
mem_busy_i  in  1  data memory not ready; whole pipeline must freeze
pc_keep_o  out  1  hold PC
if_id_keep_o  out  1  hold IF/ID
if_flush_o  out  1  zero IF/ID
id_ex_keep_o  out  1  hold ID/EX
id_ex_bubble_o  out  1  load zero (NOP) into ID/EX
ex_mem_keep_o  out  1  hold EX/MEM
mem_timeout_o  out  1  sticky error flag
state_o  out  2  current FSM state, for debug

Behaviour:
- Reset is asynchronous, active-low:
  - state goes to RUN, the bubble counter and the wait counter clear, mem_timeout_o clears.
  - While rst_ni is low, all outputs are forced to 0.
- hazard = ex_mem_read_i & (ex_rd_i != 0) & ((id_uses_rs_i & id_rs_i == ex_rd_i) | (id_uses_rt_i & id_rt_i == ex_rd_i)).
- stall = pc_keep_o + if_id_keep_o + id_ex_bubble_o all 1, with id_ex_keep_o = 0 and ex_mem_keep_o = 0.
- freeze = all four keeps 1, with if_flush_o = 0 and id_ex_bubble_o = 0.
- States, encoded in state_o: RUN = 0, LOAD_STALL = 1, MEM_WAIT = 2.
- Outputs are combinational from state and inputs. Priority is freeze > stall > flush.
- RUN:
  - mem_busy_i: freeze; go to MEM_WAIT; the wait counter loads 1.
  - else hazard: stall. If LOAD_BUBBLES > 1, go to LOAD_STALL with the bubble counter = LOAD_BUBBLES-1.
  - else id_redirect_i: if_flush_o = 1 for this cycle only.
- LOAD_STALL:
  - Stall is asserted unconditionally and id_redirect_i is ignored.
  - The bubble counter decrements each cycle. Return to RUN in the cycle after the counter reads 1.
  - mem_busy_i overrides: freeze is asserted, the bubble counter is paused (not decremented), and the FSM goes to MEM_WAIT. The remaining bubbles resume afterwards.
- MEM_WAIT:
  - Freeze while mem_busy_i = 1; the wait counter increments, saturating.
  - When mem_busy_i drops:
    - if the bubble counter != 0, go to LOAD_STALL;
    - otherwise go to RUN and re-evaluate hazard and redirect normally in that same cycle.
  - The wait counter clears on exit.
- A redirect that coincides with a stall or freeze is dropped, not queued. The ID instruction is held and re-presents id_redirect_i later.
- mem_timeout_o sets when the wait counter reaches MEM_TIMEOUT. It stays set until reset and does not change sequencing.
- ex_rd_i == 0 never causes a hazard.

Optional Feature:
HAZ_PERF_CNT_EN.
- Defined:
  - Adds output ports stall_cnt_o [31:0], flush_cnt_o [31:0] and freeze_cnt_o [31:0].
  - Each counter is saturating and increments on every cycle its condition is asserted.
  - Each counter clears on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - the state encoding constants (RUN, LOAD_STALL, MEM_WAIT);
  - the STATE_W = 2 constant;
  - the NOP encoding 32'd0 used by the bubble path.
- Sub-module haz_detect: purely combinational load-use comparator producing hazard. It is reused later for forwarding-unit checks.

Test Plan:
- Load writes rd = 5 in EX, ID reads rs = 5 with LOAD_BUBBLES = 1 -> exactly 1 cycle of pc_keep_o / if_id_keep_o / id_ex_bubble_o = 1, then RUN.
- Same stimulus with ex_rd_i = 0, or with id_uses_rs_i = 0 -> no stall; all outputs 0.
- id_redirect_i together with a load-use hazard -> stall only, if_flush_o = 0. Next cycle, hazard gone and redirect held -> if_flush_o = 1 for 1 cycle.
- LOAD_BUBBLES = 3, mem_busy_i high for 4 cycles starting in the 2nd bubble cycle -> 4 freeze cycles, then the 2 remaining stall cycles, then RUN; state_o sequence is 1, 2, 2, 2, 2, 1, 1, 0.
- MEM_TIMEOUT = 8, mem_busy_i held for 10 cycles -> mem_timeout_o rises on the 8th freeze cycle and stays 1 after mem_busy_i falls. Assert rst_ni low mid-wait -> all outputs 0 immediately, state_o = 0.
- With HAZ_PERF_CNT_EN defined: 3 stalls, 2 flushes and 5 freeze cycles -> stall_cnt_o = 3, flush_cnt_o = 2, freeze_cnt_o = 5.
